m81: RTL and testbench
======================

M81 -- requirements
Module: m81

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the select-change counter; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all registers update on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports D0..D7  input  1 each  data inputs 0..7.
REQ-005 SHALL have ports S0, S1, S2  input  1 each  select; S2 MSB, S0 LSB, sel = {S2,S1,S0}.
REQ-006 SHALL have port out  output  1  combinational mux output.
REQ-007 SHALL have port out_q  output  1  registered copy of out.
REQ-008 SHALL have port sel_q  output  3  registered copy of sel.
REQ-009 SHALL have port sel_chg  output  1  one-cycle pulse on select change.
REQ-010 SHALL have port chg_cnt  output  CNT_W  saturating count of select changes.
REQ-011 Design decision: one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-012 out SHALL equal D[sel] combinationally: sel=0->D0, 1->D1, 2->D2, 3->D3, 4->D4, 5->D5, 6->D6, 7->D7.
REQ-013 out SHALL have no dependence on clk or rst_n; it stays correct with clk undriven or rst_n low.
REQ-014 out SHALL follow any data or select input change with zero clock latency, no glitch requirement beyond settled logic value.
REQ-015 X/Z on the selected D input SHALL propagate to out; X/Z on unselected D inputs SHALL NOT affect out.
REQ-016 On each rising clk edge with rst_n high, out_q SHALL load out (1-cycle latency).
REQ-017 On each rising clk edge with rst_n high, sel_q SHALL load sel.
REQ-018 sel_chg SHALL be registered: set to 1 on an edge where sel != sel_q (value before that edge), else 0.
REQ-019 sel_chg SHALL be high exactly one cycle per edge on which sel differs from sel_q; consecutive changes on consecutive edges SHALL give consecutive pulses.
REQ-020 chg_cnt SHALL increment by 1 on every edge where sel != sel_q, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-021 With a select change at saturation, sel_chg SHALL still pulse while chg_cnt holds at max.
REQ-022 Data-input changes with sel unchanged SHALL NOT affect sel_chg or chg_cnt.
REQ-023 First edge after reset release SHALL compare sel against sel_q = 0; sel != 0 there counts as a change.

Reset
REQ-024 While rst_n is low, out_q=0, sel_q=3'b000, sel_chg=0, chg_cnt=0, applied immediately without a clock edge.
REQ-025 Reset asserted mid-operation SHALL clear all registered outputs at once; out keeps tracking D[sel].
REQ-026 Registers SHALL resume on the first rising clk edge after rst_n goes high.

Verification
REQ-027 Clockless: clk=0, rst_n=0, D0..D7 each toggled at periods 2,4,...,16 ns, S0/S1/S2 at 18/20/22 ns, run 500 ns -> out == D[{S2,S1,S0}] at every change.
REQ-028 Exhaustive: all 2^11 combinations of D0..D7,S0..S2 -> out matches D[sel]; e.g. D=8'b1000_0000 (D7=1), sel=7 -> out=1, sel=6 -> out=0.
REQ-029 Registered: rst_n=1, sel=5, D5=1, one edge -> out_q=1, sel_q=5, sel_chg=1, chg_cnt=1; next edge sel held -> sel_chg=0, chg_cnt=1.
REQ-030 Saturation: CNT_W=2, alternate sel 1/2 on 5 edges -> chg_cnt 1,2,3,3,3; sel_chg=1 each edge.
REQ-031 Async reset: chg_cnt=3, out_q=1, drop rst_n between edges -> all registered outputs 0 immediately; out still equals D[sel].
REQ-032 Data-only activity: sel fixed at 3, toggle D3 every cycle -> out_q follows D3 with 1-cycle lag, sel_chg=0, chg_cnt unchanged.

Source files
------------

// File: rtl/m81.sv
// 8:1 single-bit multiplexer with registered output/select copies and a
// saturating counter of select changes.
module m81 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D0,
  input  logic             D1,
  input  logic             D2,
  input  logic             D3,
  input  logic             D4,
  input  logic             D5,
  input  logic             D6,
  input  logic             D7,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  output logic             out,
  output logic             out_q,
  output logic [2:0]       sel_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + CNT_ONE;
  endfunction

  logic [7:0]       d_p0;
  logic [2:0]       sel_p0;
  logic             changed_p0;

  logic             out_p1;
  logic [2:0]       sel_p1;
  logic             chg_p1;
  logic [CNT_W-1:0] cnt_p1;

  // stage p0: purely combinational select, independent of clk and rst_n
  assign d_p0       = {D7, D6, D5, D4, D3, D2, D1, D0};
  assign sel_p0     = {S2, S1, S0};
  assign out        = d_p0[sel_p0];
  assign changed_p0 = (sel_p0 != sel_p1);

  // stage p1: registered copies and change tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= 1'b0;
      sel_p1 <= 3'b000;
      chg_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      out_p1 <= out;
      sel_p1 <= sel_p0;
      chg_p1 <= changed_p0;
      if (changed_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign out_q   = out_p1;
  assign sel_q   = sel_p1;
  assign sel_chg = chg_p1;
  assign chg_cnt = cnt_p1;

endmodule

// File: tb/tb_m81.sv
// Randomized self-checking bench for m81, compared against a behavioural
// model; runs a default-width and a 2-bit-counter instance side by side.
module tb_m81;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic [7:0] d;
  logic [2:0] s;

  logic       out8, outq8, chg8;
  logic [2:0] selq8;
  logic [7:0] cnt8;
  logic       out2, outq2, chg2;
  logic [2:0] selq2;
  logic [1:0] cnt2;

  int checks;
  int failures;

  // behavioural model state
  logic       m_outq;
  logic [2:0] m_selq;
  logic       m_chg;
  int         m_cnt8;
  int         m_cnt2;

  m81 dut8 (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .S0(s[0]), .S1(s[1]), .S2(s[2]),
    .out(out8), .out_q(outq8), .sel_q(selq8), .sel_chg(chg8), .chg_cnt(cnt8)
  );

  m81 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .S0(s[0]), .S1(s[1]), .S2(s[2]),
    .out(out2), .out_q(outq2), .sel_q(selq2), .sel_chg(chg2), .chg_cnt(cnt2)
  );

  initial clk = 1'b0;
  always begin
    #5;
    clk = clk_run ? ~clk : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic mux_ref(input logic [7:0] dv, input logic [2:0] sv);
    logic [7:0] sh;
    sh = dv >> sv;
    return sh[0];
  endfunction

  task automatic model_reset();
    m_outq = 1'b0;
    m_selq = 3'd0;
    m_chg  = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  task automatic model_edge();
    bit changed;
    changed = (s != m_selq);
    m_outq  = mux_ref(d, s);
    m_selq  = s;
    m_chg   = changed;
    if (changed) begin
      m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
      m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out8"},  {31'd0, out8},  {31'd0, mux_ref(d, s)});
    check({tag, ".out2"},  {31'd0, out2},  {31'd0, mux_ref(d, s)});
    check({tag, ".out_q"}, {31'd0, outq8}, {31'd0, m_outq});
    check({tag, ".sel_q"}, {29'd0, selq8}, {29'd0, m_selq});
    check({tag, ".chg"},   {31'd0, chg8},  {31'd0, m_chg});
    check({tag, ".cnt8"},  {24'd0, cnt8},  m_cnt8);
    check({tag, ".chg2"},  {31'd0, chg2},  {31'd0, m_chg});
    check({tag, ".cnt2"},  {30'd0, cnt2},  m_cnt2);
    check({tag, ".out_q2"}, {31'd0, outq2}, {31'd0, m_outq});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int sat_exp[5];
    checks   = 0;
    failures = 0;
    clk_run  = 1'b0;
    rst_n    = 1'b0;
    d        = 8'd0;
    s        = 3'd0;
    model_reset();
    #1;
    check_all("reset");

    // clockless toggling with reset held
    for (int t = 1; t <= 500; t++) begin
      #1;
      for (int i = 0; i < 8; i++)
        if (t % (2 * (i + 1)) == 0) d[i] = ~d[i];
      if (t % 18 == 0) s[0] = ~s[0];
      if (t % 20 == 0) s[1] = ~s[1];
      if (t % 22 == 0) s[2] = ~s[2];
      #0;
      check("clockless.out", {31'd0, out8}, {31'd0, mux_ref(d, s)});
    end
    check_all("clockless.regs");

    // exhaustive combinational sweep
    for (int v = 0; v < 2048; v++) begin
      d = v[7:0];
      s = v[10:8];
      #1;
      check("exh.out8", {31'd0, out8}, {31'd0, ((v >> (v >> 8)) & 1) != 0});
      check("exh.out2", {31'd0, out2}, {31'd0, ((v >> (v >> 8)) & 1) != 0});
    end

    // X on selected vs unselected input
    d = 8'b1000_0000;
    d[2] = 1'bx;
    s = 3'd7; #1; check("x.unsel7", {31'd0, out8}, 32'd1);
    s = 3'd6; #1; check("x.unsel6", {31'd0, out8}, 32'd0);
    s = 3'd2; #1; check("x.sel",    {31'd0, out8}, {31'd0, 1'bx});
    d = 8'd0; s = 3'd0;

    // start clock, release reset away from an edge
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    s = 3'd5;
    d = 8'b0010_0000;
    tick("first");
    check("first.cnt_const", {24'd0, cnt8}, 32'd1);
    tick("hold");
    check("hold.chg_const", {31'd0, chg8}, 32'd0);

    // reset, then saturation sequence with data all ones
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    #1 rst_n = 1'b1;
    d = 8'hFF;
    sat_exp = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      s = (k % 2 == 0) ? 3'd1 : 3'd2;
      tick("sat");
      check("sat.cnt2", {30'd0, cnt2}, sat_exp[k]);
      check("sat.chg2", {31'd0, chg2}, 32'd1);
    end

    // async reset between edges at saturation
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.out", {31'd0, out8}, {31'd0, mux_ref(d, s)});
    #1 rst_n = 1'b1;

    // data-only activity with sel fixed
    s = 3'd3;
    tick("data_sel");
    for (int k = 0; k < 6; k++) begin
      d[3] = ~d[3];
      tick("data_only");
      check("data_only.chg", {31'd0, chg8}, 32'd0);
    end

    // randomized run
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) != 0) s = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      tick("rand");
      if (it % 97 == 50) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("rand_rst");
        #1 rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
